// File: rtl/ch2_pkg.sv
// Shared constants for the registered 3-to-8 decoder: line/code widths and FSM state encodings.
package ch2_pkg;
    localparam int ONEHOT_W = 8;
    localparam int CODE_W   = 3;

    typedef logic [1:0] state_t;
    localparam state_t IDLE = 2'd0;
    localparam state_t HOLD = 2'd1;
    localparam state_t SCAN = 2'd2;
endpackage

// File: rtl/ch2_38decoder_seq_if.sv
// Control/handshake bus between a line-select issuer (master) and the decoder (slave).
interface ch2_38decoder_seq_if;
    import ch2_pkg::*;

    logic                en;
    logic                mode;
    logic [CODE_W-1:0]   a;
    logic                valid;
    logic                ready;
    logic [ONEHOT_W-1:0] o;
    logic                done;

    modport master (output en, mode, a, valid, input ready, o, done);
    modport slave  (input en, mode, a, valid, output ready, o, done);
endinterface

// File: rtl/ch2_prescaler.sv
// Divide-by-DIV counter: tick is high on the last count of each DIV-cycle window.
module ch2_prescaler #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int PW = $clog2(DIV + 1);

    logic [PW-1:0] cnt;

    assign tick = en & ~clr & (cnt == PW'(DIV - 1));

    // Count 0..DIV-1 while enabled; clear has priority and parks the count at 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == PW'(DIV - 1)) cnt <= '0;
            else                     cnt <= cnt + PW'(1);
        end
    end
endmodule

// File: rtl/ch2_38decoder_seq.sv
// Registered 3-to-8 one-hot decoder with a timed command mode and a prescaled auto-scan mode.
module ch2_38decoder_seq
    import ch2_pkg::*;
#(
    parameter int HOLD_CYC = 4,
    parameter int DIV      = 2
) (
    input logic clk,
    input logic rst,
    ch2_38decoder_seq_if.slave bus
);
    localparam int HCW = $clog2(HOLD_CYC + 1);

    state_t              state;
    logic [HCW-1:0]      hold_cnt;
    logic [ONEHOT_W-1:0] o_q;
    logic                done_q;
    logic                handshake;
    logic                scan_on;
    logic                scan_clr;
    logic                scan_tick;

    // Ready is purely a function of registered state plus the live enables.
    assign bus.ready = (state == IDLE) & bus.en & ~bus.mode;
    assign handshake = bus.valid & bus.ready;
    assign bus.o     = o_q;
    assign bus.done  = done_q;

    // Prescaler is held at 0 outside SCAN and on the abort edge, so each scan starts fresh.
    assign scan_on  = bus.en & bus.mode;
    assign scan_clr = (state != SCAN) | ~scan_on;

    ch2_prescaler #(.DIV(DIV)) u_scan_div (
        .clk  (clk),
        .rst  (rst),
        .clr  (scan_clr),
        .en   (state == SCAN),
        .tick (scan_tick)
    );

    // Main FSM: output lines, hold countdown and the one-cycle done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            o_q      <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (scan_on) begin
                        state <= SCAN;
                        o_q   <= ONEHOT_W'(1);
                    end else if (handshake) begin
                        state    <= HOLD;
                        o_q      <= ONEHOT_W'(1) << bus.a;
                        hold_cnt <= HCW'(HOLD_CYC - 1);
                    end
                end
                HOLD: begin
                    // EN low freezes both the line and the countdown.
                    if (bus.en) begin
                        if (hold_cnt == '0) begin
                            state  <= IDLE;
                            o_q    <= '0;
                            done_q <= 1'b1;
                        end else begin
                            hold_cnt <= hold_cnt - HCW'(1);
                        end
                    end
                end
                SCAN: begin
                    if (!scan_on) begin
                        state <= IDLE;
                        o_q   <= '0;
                    end else if (scan_tick) begin
                        o_q <= {o_q[ONEHOT_W-2:0], o_q[ONEHOT_W-1]};
                    end
                end
                default: begin
                    state <= IDLE;
                    o_q   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_ch2_38decoder_seq.sv
// Directed, table-driven bench for ch2_38decoder_seq (HOLD_CYC=4, DIV=2).
module tb_ch2_38decoder_seq;
    logic clk;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;

    ch2_38decoder_seq_if bus();

    ch2_38decoder_seq #(.HOLD_CYC(4), .DIV(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] a;
        logic [7:0] o;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Paired 8-to-3 encoder: index of the asserted line.
    function automatic logic [2:0] enc(input logic [7:0] o);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) if (o[i]) r = 3'(i);
        return r;
    endfunction

    // Lines must never be multi-hot.
    always @(negedge clk) chk("onehot0", 32'($onehot0(bus.o)), 32'd1);

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int on_cnt;
        int done_cnt;
        int wrong_val;

        vecs[0] = '{3'd0, 8'h01};
        vecs[1] = '{3'd1, 8'h02};
        vecs[2] = '{3'd2, 8'h04};
        vecs[3] = '{3'd3, 8'h08};
        vecs[4] = '{3'd4, 8'h10};
        vecs[5] = '{3'd5, 8'h20};
        vecs[6] = '{3'd6, 8'h40};
        vecs[7] = '{3'd7, 8'h80};

        rst = 1'b1; bus.en = 1'b1; bus.mode = 1'b0; bus.a = 3'd0; bus.valid = 1'b0;
        tick; tick;
        chk("rst_o", 32'(bus.o), 32'h00);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        rst = 1'b0;
        tick;

        // Single command A=5: four cycles of 0x20, then done with O=0.
        bus.a = 3'd5; bus.valid = 1'b1;
        #1 chk("single_ready_idle", 32'(bus.ready), 32'd1);
        tick;
        bus.valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("single_o", 32'(bus.o), 32'h20);
            chk("single_ready_hold", 32'(bus.ready), 32'd0);
            chk("single_done_early", 32'(bus.done), 32'd0);
            tick;
        end
        chk("single_o_end", 32'(bus.o), 32'h00);
        chk("single_done", 32'(bus.done), 32'd1);
        chk("single_ready_done", 32'(bus.ready), 32'd1);
        tick;
        chk("single_done_width", 32'(bus.done), 32'd0);

        // Back-to-back round trip, each new command issued in the done cycle.
        for (int i = 0; i < 8; i++) begin
            bus.a = vecs[i].a; bus.valid = 1'b1;
            #1 chk("rt_ready", 32'(bus.ready), 32'd1);
            tick;
            bus.valid = 1'b0;
            for (int k = 0; k < 4; k++) begin
                chk("rt_o", 32'(bus.o), 32'(vecs[i].o));
                chk("rt_enc", 32'(enc(bus.o)), 32'(vecs[i].a));
                tick;
            end
            chk("rt_done", 32'(bus.done), 32'd1);
            chk("rt_o_end", 32'(bus.o), 32'h00);
        end
        tick;

        // Pause: EN low for three edges during HOLD stretches assertion to 7 cycles.
        bus.a = 3'd6; bus.valid = 1'b1;
        tick;
        bus.valid = 1'b0;
        on_cnt = 0; done_cnt = 0; wrong_val = 0;
        for (int c = 0; c < 20; c++) begin
            if (bus.o != 8'h00) on_cnt++;
            if (bus.o != 8'h00 && bus.o != 8'h40) wrong_val++;
            if (bus.done) begin
                done_cnt++;
                chk("pause_o_at_done", 32'(bus.o), 32'h00);
            end
            bus.en = !(c >= 1 && c <= 3);
            tick;
        end
        bus.en = 1'b1;
        chk("pause_on_cycles", 32'(on_cnt), 32'd7);
        chk("pause_done_count", 32'(done_cnt), 32'd1);
        chk("pause_value", 32'(wrong_val), 32'd0);

        // Asynchronous reset mid-HOLD drops the command with no done.
        bus.a = 3'd6; bus.valid = 1'b1;
        tick;
        bus.valid = 1'b0;
        tick;
        chk("pre_rst_o", 32'(bus.o), 32'h40);
        #3 rst = 1'b1;
        #1;
        chk("async_rst_o", 32'(bus.o), 32'h00);
        chk("async_rst_done", 32'(bus.done), 32'd0);
        tick;
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(bus.ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("post_rst_done", 32'(bus.done), 32'd0);
            chk("post_rst_o", 32'(bus.o), 32'h00);
            tick;
        end

        // Priority: MODE and VALID together in IDLE start SCAN, no command taken.
        bus.mode = 1'b1; bus.valid = 1'b1; bus.a = 3'd3;
        #1 chk("prio_ready", 32'(bus.ready), 32'd0);
        tick;
        bus.valid = 1'b0;
        for (int c = 0; c < 18; c++) begin
            chk("scan_o", 32'(bus.o), 32'(8'h01 << ((c / 2) % 8)));
            chk("scan_done", 32'(bus.done), 32'd0);
            tick;
        end
        chk("scan_mid", 32'(bus.o), 32'h02);
        bus.mode = 1'b0;
        tick;
        chk("scan_abort_o", 32'(bus.o), 32'h00);
        chk("scan_abort_done", 32'(bus.done), 32'd0);
        chk("scan_abort_ready", 32'(bus.ready), 32'd1);

        // EN low also aborts a scan; restart begins at line 0 again.
        bus.mode = 1'b1;
        tick; tick; tick;
        chk("scan2_o", 32'(bus.o), 32'h02);
        bus.en = 1'b0;
        tick;
        chk("scan_en_abort_o", 32'(bus.o), 32'h00);
        bus.en = 1'b1;
        tick;
        chk("scan_restart_o", 32'(bus.o), 32'h01);
        tick;
        chk("scan_restart_o2", 32'(bus.o), 32'h01);
        bus.mode = 1'b0;
        tick;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
